// File: rtl/sloth_pipe_pkg.sv
// Shared pipeline-stage definitions: stage occupancy encoding and default field widths.
package sloth_pipe_pkg;

    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CTRL_W = 10;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones, clears only on reset.
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer and synchronous flush.
// Optional stall/flush performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import sloth_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = PIPE_DATA_W,
    parameter int CTRL_WIDTH = PIPE_CTRL_W
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid and payload stay stable until accepted, and both readies come from state only.
    pipe_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic                  in_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            // Payload bits are left in place; only the control is killed.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (in_fire && out_ready) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_ready) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = out_valid & ~out_ready;
    assign flush_inc = flush & (state_q != EMPTY);

    pipe_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_skid;

    localparam int DW = 128;
    localparam int CWD = 10;
    localparam int NW = 4;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [CWD-1:0] in_ctrl;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [CWD-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
    logic [NW-1:0]  stall_cnt;
    logic [NW-1:0]  flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the stage is a FIFO of capacity two, head shown on the outputs.
    logic [DW-1:0]  exp_q[$];
    logic [CWD-1:0] ctl_q[$];
    logic [NW-1:0]  stall_m;
    logic [NW-1:0]  flush_m;

    pipe_stage_skid #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CWD)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_WIDTH  (NW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        exp_q.delete();
        ctl_q.delete();
        stall_m = '0;
        flush_m = '0;
    endtask

    // One clock: sample the driven inputs at the rising edge, advance the model, return at the falling edge.
    task automatic clk_step();
        bit inf;
        bit outf;
        @(posedge clk);
        inf  = in_valid && (exp_q.size() < 2);
        outf = out_ready && (exp_q.size() > 0);
        if ((exp_q.size() > 0) && !out_ready && (stall_m != '1)) stall_m = stall_m + 1'b1;
        if (flush) begin
            if ((exp_q.size() > 0) && (flush_m != '1)) flush_m = flush_m + 1'b1;
            exp_q.delete();
            ctl_q.delete();
        end else begin
            if (outf) begin
                void'(exp_q.pop_front());
                void'(ctl_q.pop_front());
            end
            if (inf) begin
                exp_q.push_back(in_data);
                ctl_q.push_back(in_ctrl);
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl: got %h expected 0", out_ctrl); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
`ifdef PIPE_STAGE_PERF_EN
        checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cnt, flush_cnt); end
`endif
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = rand_data(); in_ctrl = 10'h3ff; clk_step();
        in_data = rand_data(); in_ctrl = 10'h155; clk_step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_full: got in_ready %b expected 0", in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL midrst_out_ctrl: got %h expected 0", out_ctrl); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        clk_step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_lost: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [CWD-1:0] c;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            c = CWD'($urandom);
            in_valid = 1'b1; in_data = DW'(i); in_ctrl = c;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
            clk_step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== c) begin
                errors++;
                $display("FAIL stream_out[%0d]: got v=%b d=%h c=%h expected v=1 d=%h c=%h", i, out_valid, out_data, out_ctrl, DW'(i), c);
            end
        end
        in_valid = 1'b0;
        clk_step();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin errors++; $display("FAIL stream_drain: got v=%b c=%h expected v=0 c=0", out_valid, out_ctrl); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] d[3];
        d[0] = DW'(128'haaaa); d[1] = DW'(128'hbbbb); d[2] = DW'(128'hcccc);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = d[i]; in_ctrl = CWD'(i + 1);
            clk_step();
            checks++; if (out_valid !== 1'b1 || out_data !== d[0] || out_ctrl !== CWD'(1)) begin errors++; $display("FAIL bp_hold_a[%0d]: got d=%h c=%h expected d=%h c=1", i, out_data, out_ctrl, d[0]); end
            checks++; if (in_ready !== (i == 0)) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, (i == 0)); end
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            clk_step();
            checks++; if (out_valid !== 1'b1 || out_data !== d[i] || out_ctrl !== CWD'(i + 1)) begin errors++; $display("FAIL bp_order[%0d]: got d=%h c=%h expected d=%h c=%h", i, out_data, out_ctrl, d[i], CWD'(i + 1)); end
        end
        in_valid = 1'b0;
        clk_step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'(128'h11); in_ctrl = 10'h011; clk_step();
        in_data = DW'(128'h22); in_ctrl = 10'h022; clk_step();
        flush = 1'b1; in_data = DW'(128'hd); in_ctrl = 10'h0dd; clk_step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_full: got v=%b c=%h r=%b expected v=0 c=0 r=1", out_valid, out_ctrl, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_d_gone[%0d]: got out_valid %b expected 0", i, out_valid); end
        end
`ifdef PIPE_STAGE_PERF_EN
        checks++; if (flush_cnt !== NW'(1)) begin errors++; $display("FAIL flush_cnt_one: got %0d expected 1", flush_cnt); end
`endif
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'(128'he); in_ctrl = 10'h0ee; clk_step();
        flush = 1'b1; in_data = DW'(128'hf); in_ctrl = 10'h0ff; clk_step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin errors++; $display("FAIL flush_one_fire: got v=%b c=%h expected v=0 c=0", out_valid, out_ctrl); end
        flush = 1'b1; clk_step();
        flush = 1'b0; clk_step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_f_gone: got out_valid %b expected 0", out_valid); end
`ifdef PIPE_STAGE_PERF_EN
        checks++; if (flush_cnt !== NW'(2)) begin errors++; $display("FAIL flush_cnt_two: got %0d expected 2", flush_cnt); end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_data   = rand_data();
            in_ctrl   = CWD'($urandom);
            clk_step();
            checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", n, out_valid, (exp_q.size() > 0)); end
            checks++; if (in_ready !== (exp_q.size() < 2)) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, in_ready, (exp_q.size() < 2)); end
            if (exp_q.size() > 0) begin
                checks++; if (out_data !== exp_q[0] || out_ctrl !== ctl_q[0]) begin errors++; $display("FAIL rand_head[%0d]: got d=%h c=%h expected d=%h c=%h", n, out_data, out_ctrl, exp_q[0], ctl_q[0]); end
            end else begin
                checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL rand_idle_ctrl[%0d]: got %h expected 0", n, out_ctrl); end
            end
`ifdef PIPE_STAGE_PERF_EN
            checks++; if (stall_cnt !== stall_m || flush_cnt !== flush_m) begin errors++; $display("FAIL rand_counters[%0d]: got %0d/%0d expected %0d/%0d", n, stall_cnt, flush_cnt, stall_m, flush_m); end
`endif
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_saturation();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = rand_data(); in_ctrl = 10'h001; clk_step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) clk_step();
        checks++; if (stall_cnt !== NW'(15) || stall_m !== NW'(15)) begin errors++; $display("FAIL sat_stall: got %0d expected 15", stall_cnt); end
        clk_step();
        checks++; if (stall_cnt !== NW'(15)) begin errors++; $display("FAIL sat_hold: got %0d expected 15", stall_cnt); end
        out_ready = 1'b1; clk_step();
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_streaming();
        test_back_pressure();
        test_reset_mid();
        test_flush();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
